// File: rtl/dec_stage_pkg.sv
// dec_stage_pkg: shared opcode/field constants and occupancy encoding for the decode stage
package dec_stage_pkg;
  localparam int OP_W  = 6;
  localparam int REG_W = 5;
  localparam int IMM_W = 16;
  localparam logic [OP_W-1:0] OP_ANDI = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI  = 6'h0D;
  localparam logic [OP_W-1:0] OP_XORI = 6'h0E;
  localparam logic [OP_W-1:0] OP_LUI  = 6'h0F;
  typedef enum logic [1:0] {OCC_EMPTY, OCC_PARTIAL, OCC_FULL} occ_t;
  function automatic logic [31:0] sext16(input logic [IMM_W-1:0] v);
    return {{(32-IMM_W){v[IMM_W-1]}}, v};
  endfunction
endpackage

// File: rtl/dec_fields.sv
// dec_fields: combinational MIPS field split with extended immediate, jump and branch targets
module dec_fields
  import dec_stage_pkg::*;
(
  input  logic [31:0]      instr,
  input  logic [31:0]      pc4,
  output logic [OP_W-1:0]  op,
  output logic [REG_W-1:0] rs,
  output logic [REG_W-1:0] rt,
  output logic [REG_W-1:0] rd,
  output logic [REG_W-1:0] shamt,
  output logic [OP_W-1:0]  func,
  output logic [IMM_W-1:0] imm16,
  output logic [31:0]      imm_ext,
  output logic [31:0]      index,
  output logic [31:0]      br_target
);
  logic [31:0] sx;
  logic        logical_op;
  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign shamt = instr[10:6];
  assign func  = instr[5:0];
  assign imm16 = instr[15:0];
  assign sx    = sext16(instr[15:0]);
  always_comb begin
    logical_op = (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
    imm_ext    = logical_op ? {16'b0, imm16} : (op == OP_LUI) ? {imm16, 16'b0} : sx;
  end
  assign index     = {pc4[31:28], instr[25:0], 2'b00};
  assign br_target = pc4 + {sx[29:0], 2'b00};
endmodule

// File: rtl/dec_stage.sv
// dec_stage: FIFO-buffered MIPS decode stage with flush; DEC_PERF_EN adds stall/issue counters
module dec_stage
  import dec_stage_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc4,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OP_W-1:0]  op,
  output logic [REG_W-1:0] rs,
  output logic [REG_W-1:0] rt,
  output logic [REG_W-1:0] rd,
  output logic [REG_W-1:0] shamt,
  output logic [OP_W-1:0]  func,
  output logic [IMM_W-1:0] imm16,
  output logic [31:0]      imm_ext,
  output logic [31:0]      index,
  output logic [31:0]      br_target,
  output logic [31:0]      out_pc4
`ifdef DEC_PERF_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      issue_cnt
`endif
);
  localparam int PTR_W = $clog2(DEPTH);
  logic [63:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [63:0]      head;
  occ_t             occ;
  logic             push, pop;
  always_comb begin
    occ       = (count == '0) ? OCC_EMPTY : (count == CNT_W'(DEPTH)) ? OCC_FULL : OCC_PARTIAL;
    in_ready  = occ != OCC_FULL;
    out_valid = occ != OCC_EMPTY;
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end
  // storage is intentionally unreset; contents are only observed behind out_valid
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= {in_instr, in_pc4};
  end
  assign head    = mem[rd_ptr];
  assign out_pc4 = head[31:0];
  dec_fields u_fields (
    .instr    (head[63:32]),
    .pc4      (head[31:0]),
    .op       (op),
    .rs       (rs),
    .rt       (rt),
    .rd       (rd),
    .shamt    (shamt),
    .func     (func),
    .imm16    (imm16),
    .imm_ext  (imm_ext),
    .index    (index),
    .br_target(br_target)
  );
`ifdef DEC_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      issue_cnt <= '0;
    end else begin
      if (out_valid && !out_ready) stall_cnt <= stall_cnt + 1'b1;
      if (pop && !flush) issue_cnt <= issue_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_dec_stage.sv
// tb_dec_stage: scoreboard bench for dec_stage
module tb_dec_stage;
  localparam int DEPTH = 2;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, flush = 0, out_valid, out_ready = 0;
  logic [31:0] in_instr = 0, in_pc4 = 0;
  logic [5:0] op, func;
  logic [4:0] rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic [31:0] imm_ext, index, br_target, out_pc4;
`ifdef DEC_PERF_EN
  logic [31:0] stall_cnt, issue_cnt;
`endif
  int total = 0, bad = 0;
  typedef struct {logic [31:0] instr; logic [31:0] pc4;} ent_t;
  ent_t q[$];
  logic [31:0] exp_stall = 0, exp_issue = 0;
  bit acc;
  dec_stage #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc4(in_pc4), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .func(func), .imm16(imm16),
    .imm_ext(imm_ext), .index(index), .br_target(br_target), .out_pc4(out_pc4)
`ifdef DEC_PERF_EN
    , .stall_cnt(stall_cnt), .issue_cnt(issue_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ref_imm(logic [31:0] i);
    logic [15:0] h = i[15:0];
    case (i[31:26])
      6'h0C, 6'h0D, 6'h0E: return {16'h0, h};
      6'h0F: return {h, 16'h0};
      default: return {{16{h[15]}}, h};
    endcase
  endfunction
  function automatic logic [31:0] ref_br(logic [31:0] i, logic [31:0] p);
    logic [31:0] s = {{16{i[15]}}, i[15:0]};
    return p + (s << 2);
  endfunction
  task automatic cyc();
    bit do_push, do_pop;
    ent_t e;
    @(negedge clk);
    chk("out_valid", out_valid, q.size() != 0);
    chk("in_ready", in_ready, q.size() != DEPTH);
    do_push = in_valid && q.size() != DEPTH;
    do_pop  = out_ready && q.size() != 0;
    acc = 0;
    if (q.size() != 0 && !out_ready) exp_stall++;
    if (flush) q.delete();
    else begin
      if (do_pop) begin
        e = q.pop_front();
        exp_issue++;
        chk("fields", {op, rs, rt, rd, shamt, func}, e.instr);
        chk("imm16", imm16, e.instr[15:0]);
        chk("imm_ext", imm_ext, ref_imm(e.instr));
        chk("index", index, {e.pc4[31:28], e.instr[25:0], 2'b00});
        chk("br_target", br_target, ref_br(e.instr, e.pc4));
        chk("out_pc4", out_pc4, e.pc4);
      end
      if (do_push) begin
        q.push_back('{in_instr, in_pc4});
        acc = 1;
      end
    end
    @(posedge clk);
    #1;
`ifdef DEC_PERF_EN
    chk("stall_cnt", stall_cnt, exp_stall);
    chk("issue_cnt", issue_cnt, exp_issue);
`endif
  endtask
  task automatic push_hold(logic [31:0] i, logic [31:0] p);
    in_instr = i; in_pc4 = p; in_valid = 1; out_ready = 0;
    cyc();
    in_valid = 0;
    chk("hold_valid", out_valid, 1);
  endtask
  task automatic pop_one();
    out_ready = 1;
    cyc();
    out_ready = 0;
  endtask
  initial begin
    logic [31:0] w[6], p[6];
    int k, n;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
`ifdef DEC_PERF_EN
    chk("rst_stall", stall_cnt, 0);
    chk("rst_issue", issue_cnt, 0);
`endif
    push_hold(32'h2109FFFC, 32'h00400004);
    chk("addi_rs", rs, 8);
    chk("addi_rt", rt, 9);
    chk("addi_imm", imm_ext, 32'hFFFFFFFC);
    chk("addi_br", br_target, 32'h003FFFF4);
    pop_one();
    push_hold(32'h3508ABCD, 32'h00001000);
    chk("ori_imm", imm_ext, 32'h0000ABCD);
    pop_one();
    push_hold(32'h3C081234, 32'h00001000);
    chk("lui_imm", imm_ext, 32'h12340000);
    pop_one();
    push_hold(32'h08100000, 32'h90000004);
    chk("j_index", index, 32'h90400000);
    pop_one();
    for (int i = 0; i < 6; i++) begin
      w[i] = $urandom; p[i] = $urandom;
    end
    k = 0; in_valid = 1; out_ready = 0;
    for (int c = 0; c < DEPTH + 2; c++) begin
      in_instr = w[k]; in_pc4 = p[k];
      cyc();
      if (acc) k++;
    end
    chk("held_accepts", k, DEPTH);
    chk("full_in_ready", in_ready, 0);
    out_ready = 1; n = 0;
    while (k < 6 && n < 50) begin
      in_instr = w[k]; in_pc4 = p[k];
      cyc();
      if (acc) k++;
      n++;
    end
    chk("all_accepted", k, 6);
    in_valid = 0; n = 0;
    while (q.size() != 0 && n < 20) begin cyc(); n++; end
    chk("drained", q.size(), 0);
    out_ready = 0;
    push_hold(32'h11111111, 32'h00000100);
    in_instr = 32'h22222222; in_valid = 1; flush = 1;
    cyc();
    in_valid = 0; flush = 0;
    chk("flush_valid", out_valid, 0);
    chk("flush_ready", in_ready, 1);
    out_ready = 1;
    repeat (3) cyc();
    out_ready = 0; in_valid = 1;
    repeat (DEPTH) begin in_instr = $urandom; in_pc4 = $urandom; cyc(); end
    in_valid = 0;
    chk("pre_rst_full", in_ready, 0);
    rst = 1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
`ifdef DEC_PERF_EN
    chk("arst_issue", issue_cnt, 0);
`endif
    q.delete(); exp_stall = 0; exp_issue = 0;
    #1 rst = 0;
    repeat (400) begin
      in_valid = 1'($urandom_range(0, 1));
      in_instr = $urandom; in_pc4 = $urandom;
      flush = ($urandom_range(0, 15) == 0);
      out_ready = flush ? 1'b0 : 1'($urandom_range(0, 1));
      cyc();
    end
    in_valid = 0; flush = 0; out_ready = 1;
    repeat (DEPTH + 1) cyc();
    chk("final_empty", out_valid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dec_stage.md
# dec_stage

Registered, parametrised instruction-decode stage for the five-stage MIPS pipeline, placed between instruction fetch and register read. It buffers fetched instructions in a small FIFO with valid/ready handshakes on both sides and supports a pipeline flush. It presents the head instruction split into its MIPS fields plus derived values: extended immediate, absolute jump target and branch target.

## Interface
Parameters:
- DEPTH, 2, number of buffered instructions; power of two, ≥ 2
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridden)

Ports (clk, rst: one clock; reset is asynchronous and active-high):
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  stage can accept (count < DEPTH)
- in_instr  in  32  instruction word
- in_pc4  in  32  PC+4 of that instruction
- flush  in  1  discard all buffered instructions
- out_valid  out  1  head entry valid
- out_ready  in  1  register-read stage consumes head
- op  out  6  instr[31:26]
- rs  out  5  instr[25:21]
- rt  out  5  instr[20:16]
- rd  out  5  instr[15:11]
- shamt  out  5  instr[10:6]
- func  out  6  instr[5:0]
- imm16  out  16  instr[15:0]
- imm_ext  out  32  extended immediate
- index  out  32  jump target
- br_target  out  32  branch target
- out_pc4  out  32  head PC+4
- stall_cnt  out  32  DEC_PERF_EN only
- issue_cnt  out  32  DEC_PERF_EN only

## Operation
- Circular FIFO of DEPTH entries {instr, pc4}; wr_ptr, rd_ptr (log2 DEPTH bits, natural wrap), count (CNT_W bits).
- Push when in_valid && in_ready; pop when out_valid && out_ready. Simultaneous push and pop: count unchanged, both pointers advance.
- in_ready = (count != DEPTH), driven from the count register only. When full, no push occurs even if a pop happens in the same cycle.
- out_valid = (count != 0). All field outputs are combinational from the head entry and are don't-care while out_valid = 0.
- flush: next cycle count = 0 and wr_ptr = rd_ptr = 0. A push or pop in the same cycle is discarded. Flush has priority.
- Occupancy states: EMPTY (count 0), PARTIAL, FULL (count DEPTH). Transitions follow push/pop/flush only.
- imm_ext by op:
  - 0x0C/0x0D/0x0E (andi/ori/xori): {16'b0, imm16}
  - 0x0F (lui): {imm16, 16'b0}
  - all others: sign-extended imm16
- index = {pc4[31:28], instr[25:0], 2'b00}.
- br_target = pc4 + {sext(imm16)[29:0], 2'b00}, modulo 2^32.

## Timing
- Reset values: count 0, pointers 0, in_ready 1, out_valid 0, counters 0. Storage is not reset, so data outputs are don't-care.
- Latency: an instruction accepted at edge N drives out_valid = 1 and its fields after edge N (cycle N+1) if the FIFO was empty.
- Throughput: one instruction per cycle while out_ready is held high.
- Reset asserted mid-operation empties the FIFO immediately (asynchronously). In-flight data is lost.
- No combinational path exists from out_ready to in_ready.

## Configuration
- DEC_PERF_EN defined:
  - stall_cnt increments each cycle with out_valid && !out_ready.
  - issue_cnt increments on each pop.
  - Both wrap at 2^32, are cleared by rst, and are not cleared by flush.
- DEC_PERF_EN undefined: the stall_cnt and issue_cnt ports and their logic are absent.

## Structure
- The shared package holds:
  - opcode constants OP_ANDI=6'h0C, OP_ORI=6'h0D, OP_XORI=6'h0E, OP_LUI=6'h0F
  - field width constants (OP_W=6, REG_W=5, IMM_W=16)
- One sub-module, dec_fields: purely combinational field split plus imm_ext/index/br_target from {instr, pc4}, instantiated on the FIFO head.

## Test plan
- Single push: instr 0x2109FFFC (addi, imm16 0xFFFC), pc4 0x00400004 -> next cycle out_valid=1, rs=8, rt=9, imm_ext=0xFFFFFFFC, br_target=0x003FFFF4.
- ori 0x3508ABCD -> imm_ext=0x0000ABCD; lui 0x3C081234 -> imm_ext=0x12340000.
- j 0x08100000, pc4 0x90000004 -> index=0x90400000.
- out_ready=0 with DEPTH+1 pushes offered -> in_ready drops after DEPTH accepts; the extra word is held off, not lost; stall_cnt counts the held cycles; draining returns words in FIFO order, including across pointer wrap.
- flush asserted in the same cycle as a push with count=1 -> next cycle count=0, out_valid=0, in_ready=1; the pushed word never appears at the output.
- rst pulsed while FULL -> out_valid=0 and in_ready=1 immediately; issue_cnt=0.
